// File: rtl/iterative_subtractor.sv
// ----------------------------------------------------------------------------
// iterative_subtractor
//
// Multi-cycle unsigned subtractor. It computes d = a - b modulo 2^LENGTH,
// CHUNK bits per clock, by ripple-adding a + ~b + 1 one chunk at a time.
// The carry between chunks is held in a register.
//
// Handshake:
//   - Operands are accepted in IDLE (in_valid_i & in_ready_o).
//   - The result is presented in DONE until the consumer takes it
//     (out_valid_o & out_ready_i).
//   - Latency from the input transfer to out_valid_o is LENGTH/CHUNK cycles.
//
// Optional feature:
//   - Defining ITERATIVE_SUBTRACTOR_OVERFLOW_EN adds output overflow_o.
//   - overflow_o flags two's-complement signed overflow of the subtraction.
// ----------------------------------------------------------------------------
module iterative_subtractor #(
   parameter int LENGTH = 16,
   parameter int CHUNK  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [LENGTH-1:0] a_i,
   input  logic [LENGTH-1:0] b_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [LENGTH-1:0] d_o,
   output logic              borrow_o,
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
   output logic              overflow_o,
`endif
   output logic              out_valid_o,
   input  logic              out_ready_i
);

   localparam int N     = LENGTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   // Reject configurations where the chunks do not tile the word exactly.
   if ((CHUNK < 1) || (CHUNK > LENGTH) || ((LENGTH % CHUNK) != 0)) begin : g_param_check
      $error("iterative_subtractor: CHUNK must divide LENGTH and satisfy 1 <= CHUNK <= LENGTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Captured operands stay untouched for the whole operation.
   logic [LENGTH-1:0] a_q, b_q;

   // Working difference, assembled chunk by chunk.
   // Kept separate from d_q so that d_o keeps showing the previous result
   // while a new one is in flight.
   logic [LENGTH-1:0] w_q, w_d;
   logic [LENGTH-1:0] d_q;
   logic              borrow_q;
   logic              carry_q;
   logic [IDX_W-1:0]  idx_q;

   logic [CHUNK-1:0]  a_ch, b_ch;
   logic [CHUNK:0]    diff;
   logic              take_in;
   logic              busy;
   logic              last_chunk;

   // One chunk of a - b: a + ~b + carry_in.
   // The returned MSB is the chunk carry-out; a carry-out of 0 from the top
   // chunk means a borrow.
   function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             cin);
      sub_chunk = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
   endfunction

   assign take_in    = in_ready_o & in_valid_i;
   assign busy       = (state_q == BUSY);
   assign last_chunk = (idx_q == LAST_IDX);

   // State register; reset always lands in IDLE, dropping any pending work.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake outputs.
   // DONE always returns to IDLE, never straight to BUSY.
   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (last_chunk) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Select the operand chunk addressed by the current chunk index.
   always_comb begin
      a_ch = '0;
      b_ch = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_ch = a_q[k*CHUNK +: CHUNK];
            b_ch = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   assign diff = sub_chunk(a_ch, b_ch, carry_q);

   // Merge the freshly computed chunk into the working difference.
   always_comb begin
      w_d = w_q;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            w_d[k*CHUNK +: CHUNK] = diff[CHUNK-1:0];
         end
      end
   end

   // Operand capture and working difference; plain data, no reset needed.
   always_ff @(posedge clk_i) begin
      if (take_in) begin
         a_q <= a_i;
         b_q <= b_i;
      end
      if (busy) begin
         w_q <= w_d;
      end
   end

   // Chunk sequencing: the carry starts at 1 to supply the +1 of ~b + 1.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (take_in) begin
         carry_q <= 1'b1;
         idx_q   <= '0;
      end else if (busy) begin
         carry_q <= diff[CHUNK];
         idx_q   <= idx_q + IDX_W'(1);
      end
   end

   // Publish the result when the last chunk completes.
   // Outputs then hold until the next operation finishes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         d_q      <= '0;
         borrow_q <= 1'b0;
      end else if (busy && last_chunk) begin
         d_q      <= w_d;
         borrow_q <= ~diff[CHUNK];
      end
   end

   assign d_o      = d_q;
   assign borrow_o = borrow_q;

`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
   logic overflow_q;

   // Signed overflow: operands of opposite sign and a result whose sign
   // differs from the minuend.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else if (busy && last_chunk) begin
         overflow_q <= (a_q[LENGTH-1] ^ b_q[LENGTH-1]) & (w_d[LENGTH-1] ^ a_q[LENGTH-1]);
      end
   end

   assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_iterative_subtractor.sv
// ----------------------------------------------------------------------------
// tb_iterative_subtractor
//
// Directed bench for iterative_subtractor with two instances:
//   - dut0: LENGTH=16, CHUNK=4
//   - dut1: LENGTH=16, CHUNK=16
// Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_iterative_subtractor;

   logic        clk;
   logic        rst_n;

   logic [15:0] a0, b0, d0;
   logic        in_valid0, in_ready0, borrow0, out_valid0, out_ready0;
   logic [15:0] a1, b1, d1;
   logic        in_valid1, in_ready1, borrow1, out_valid1, out_ready1;
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
   logic        ovf0, ovf1;
`endif

   int total = 0;
   int bad   = 0;
   int lat;
   int seen;

   iterative_subtractor #(.LENGTH(16), .CHUNK(4)) dut0 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .a_i         (a0),
      .b_i         (b0),
      .in_valid_i  (in_valid0),
      .in_ready_o  (in_ready0),
      .d_o         (d0),
      .borrow_o    (borrow0),
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
      .overflow_o  (ovf0),
`endif
      .out_valid_o (out_valid0),
      .out_ready_i (out_ready0)
   );

   iterative_subtractor #(.LENGTH(16), .CHUNK(16)) dut1 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .a_i         (a1),
      .b_i         (b1),
      .in_valid_i  (in_valid1),
      .in_ready_o  (in_ready1),
      .d_o         (d1),
      .borrow_o    (borrow1),
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
      .overflow_o  (ovf1),
`endif
      .out_valid_o (out_valid1),
      .out_ready_i (out_ready1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands to dut0 for one edge, then count edges until out_valid.
   task automatic run_op0(input logic [15:0] a, input logic [15:0] b, output int l);
      a0 = a;
      b0 = b;
      in_valid0 = 1'b1;
      step();
      in_valid0 = 1'b0;
      l = 0;
      while (out_valid0 !== 1'b1 && l < 20) begin
         step();
         l++;
      end
   endtask

   task automatic run_op1(input logic [15:0] a, input logic [15:0] b, output int l);
      a1 = a;
      b1 = b;
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      l = 0;
      while (out_valid1 !== 1'b1 && l < 20) begin
         step();
         l++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      a0         = '0;
      b0         = '0;
      in_valid0  = 1'b0;
      out_ready0 = 1'b1;
      a1         = '0;
      b1         = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b1;

      // Reset
      step();
      step();
      check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
      check("rst_d", {16'd0, d0}, 32'h0);
      check("rst_borrow", {31'd0, borrow0}, 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);
      check("post_rst_in_ready1", {31'd0, in_ready1}, 32'd1);

      // 0x1234 - 0x0034, with a look inside BUSY
      a0 = 16'h1234;
      b0 = 16'h0034;
      in_valid0 = 1'b1;
      step();
      in_valid0 = 1'b0;
      check("busy_in_ready", {31'd0, in_ready0}, 32'd0);
      check("busy_out_valid", {31'd0, out_valid0}, 32'd0);
      step();
      check("busy_d_held", {16'd0, d0}, 32'h0);
      lat = 1;
      while (out_valid0 !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check("lat_1234", lat, 32'd4);
      check("d_1234", {16'd0, d0}, 32'h1200);
      check("borrow_1234", {31'd0, borrow0}, 32'd0);
      step();
      check("in_ready_after_xfer", {31'd0, in_ready0}, 32'd1);
      check("out_valid_after_xfer", {31'd0, out_valid0}, 32'd0);
      check("d_held_idle", {16'd0, d0}, 32'h1200);

      // 0 - 1: full wrap-around
      run_op0(16'h0000, 16'h0001, lat);
      check("lat_wrap", lat, 32'd4);
      check("d_wrap", {16'd0, d0}, 32'hFFFF);
      check("borrow_wrap", {31'd0, borrow0}, 32'd1);
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
      check("ovf_wrap", {31'd0, ovf0}, 32'd0);
`endif
      step();

      // 0x8000 - 1: signed overflow
      run_op0(16'h8000, 16'h0001, lat);
      check("d_8000", {16'd0, d0}, 32'h7FFF);
      check("borrow_8000", {31'd0, borrow0}, 32'd0);
`ifdef ITERATIVE_SUBTRACTOR_OVERFLOW_EN
      check("ovf_8000", {31'd0, ovf0}, 32'd1);
`endif
      step();

      // a == b
      run_op0(16'h5555, 16'h5555, lat);
      check("d_eq", {16'd0, d0}, 32'h0);
      check("borrow_eq", {31'd0, borrow0}, 32'd0);
      step();

      // Borrow ripples through three chunks
      run_op0(16'h1000, 16'h0001, lat);
      check("d_ripple", {16'd0, d0}, 32'h0FFF);
      check("borrow_ripple", {31'd0, borrow0}, 32'd0);
      step();

      // 0x0001 - 0xFFFF
      run_op0(16'h0001, 16'hFFFF, lat);
      check("d_1_ffff", {16'd0, d0}, 32'h0002);
      check("borrow_1_ffff", {31'd0, borrow0}, 32'd1);
      step();

      // Back-pressure: result must hold, and new operands must wait
      out_ready0 = 1'b0;
      run_op0(16'h00FF, 16'h0F00, lat);
      check("lat_bp", lat, 32'd4);
      a0 = 16'h4444;
      b0 = 16'h1111;
      in_valid0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_out_valid", {31'd0, out_valid0}, 32'd1);
         check("bp_d", {16'd0, d0}, 32'hF1FF);
         check("bp_borrow", {31'd0, borrow0}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      end
      out_ready0 = 1'b1;
      step();
      check("bp_released_in_ready", {31'd0, in_ready0}, 32'd1);
      check("bp_released_out_valid", {31'd0, out_valid0}, 32'd0);
      check("bp_released_d", {16'd0, d0}, 32'hF1FF);
      run_op0(16'h4444, 16'h1111, lat);
      check("lat_after_bp", lat, 32'd4);
      check("d_after_bp", {16'd0, d0}, 32'h3333);
      step();

      // Reset in the second BUSY cycle aborts the operation
      a0 = 16'h9999;
      b0 = 16'h1111;
      in_valid0 = 1'b1;
      step();
      in_valid0 = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_out_valid", {31'd0, out_valid0}, 32'd0);
      check("abort_d", {16'd0, d0}, 32'h0);
      check("abort_borrow", {31'd0, borrow0}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready0}, 32'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid0 === 1'b1) seen++;
      end
      check("abort_no_result", seen, 32'd0);
      check("abort_d_still_0", {16'd0, d0}, 32'h0);

      // CHUNK == LENGTH: a single BUSY cycle
      run_op1(16'hA5A5, 16'hA5A5, lat);
      check("c16_lat", lat, 32'd1);
      check("c16_d", {16'd0, d1}, 32'h0);
      check("c16_borrow", {31'd0, borrow1}, 32'd0);
      step();
      check("c16_in_ready", {31'd0, in_ready1}, 32'd1);
      run_op1(16'h0000, 16'h0001, lat);
      check("c16_lat_wrap", lat, 32'd1);
      check("c16_d_wrap", {16'd0, d1}, 32'hFFFF);
      check("c16_borrow_wrap", {31'd0, borrow1}, 32'd1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
